// File: rtl/video_pattern_gen_pkg.sv
// Shared types for the video test-pattern generator.
// Modes, register indices and the RGB bundle.
package vpg_pkg;

  typedef enum logic [2:0] {
    MODE_SOLID = 3'd0,
    MODE_CHECK = 3'd1,
    MODE_BARS  = 3'd2,
    MODE_GRAD  = 3'd3,
    MODE_BOX   = 3'd4
  } mode_e;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_COLOR = 2'd1;
  localparam logic [1:0] REG_BOXC  = 2'd2;
  localparam logic [1:0] REG_BOXG  = 2'd3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t RGB_WHITE = 24'hFFFFFF;

  // Bar 0 is white, bar 7 is black.
  function automatic rgb_t bar_rgb(logic [2:0] k);
    return {{8{~k[2]}}, {8{~k[1]}}, {8{~k[0]}}};
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Register write/read port of the pattern generator.
// Synchronous to the pixel clock.
interface video_pattern_gen_if;
  logic        i_wr;
  logic [1:0]  i_wreg;
  logic [31:0] i_wdata;
  logic [1:0]  i_rreg;
  logic [31:0] o_rdata;

  modport master (
    output i_wr, i_wreg, i_wdata, i_rreg,
    input  o_rdata
  );

  modport slave (
    input  i_wr, i_wreg, i_wdata, i_rreg,
    output o_rdata
  );
endinterface

// File: rtl/vpg_bouncer.sv
// One axis of bouncing-box motion.
// Position and direction advance once per step.
module vpg_bouncer #(
  parameter int LIMIT = 960,
  parameter int CW    = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_step,
  input  logic [7:0]  i_n,
  input  logic [7:0]  i_v,
  output logic [CW:0] o_pos
);
  localparam logic [CW:0] LIM = (CW+1)'(LIMIT);

  logic [CW:0] r_pos;
  logic        r_dir;
  logic [CW:0] w_n;
  logic [CW:0] w_v;
  logic [CW:0] w_sum;
  logic [CW:0] w_nxt;
  logic        w_ndir;

  assign w_n   = {{(CW-7){1'b0}}, i_n};
  assign w_v   = {{(CW-7){1'b0}}, i_v};
  assign w_sum = r_pos + w_v + w_n;

  always_comb begin
    w_nxt  = r_pos;
    w_ndir = r_dir;
    if (!r_dir) begin
      if (w_sum > LIM) begin
        // Oversized boxes pin to the origin edge.
        w_nxt  = (w_n >= LIM) ? '0 : LIM - w_n;
        w_ndir = 1'b1;
      end else begin
        w_nxt = r_pos + w_v;
      end
    end else if (r_pos < w_v) begin
      w_nxt  = '0;
      w_ndir = 1'b0;
    end else begin
      w_nxt = r_pos - w_v;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos <= '0;
      r_dir <= 1'b0;
    end else if (i_step) begin
      r_pos <= w_nxt;
      r_dir <= w_ndir;
    end
  end

  assign o_pos = r_pos;
endmodule

// File: rtl/video_pattern_gen.sv
// Register-programmable video test-pattern source.
// Settings are shadowed at frame start; RGB has 2-cycle latency.
module video_pattern_gen
  import vpg_pkg::*;
#(
  parameter int HWIDTH  = 960,
  parameter int VHEIGHT = 600,
  parameter int CW      = 11
) (
  input  logic          clk,
  input  logic          reset,
  video_pattern_gen_if.slave regs,
  input  logic [CW-1:0] xpixel,
  input  logic [CW-1:0] ypixel,
  output logic [7:0]    red,
  output logic [7:0]    grn,
  output logic [7:0]    blu,
  output logic          o_frame
);
  localparam int BAR_W = HWIDTH / 8;
  localparam int BCW   = $clog2(BAR_W);
  localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);
  localparam logic [CW-1:0]  HMAX     = CW'(HWIDTH);
  localparam logic [CW-1:0]  VMAX     = CW'(VHEIGHT);

  logic [2:0]     r_mode;
  logic [3:0]     r_shift;
  rgb_t           r_color;
  rgb_t           r_boxc;
  logic [7:0]     r_boxn;
  logic [7:0]     r_boxv;

  mode_e          r_s_mode;
  logic [3:0]     r_s_shift;
  rgb_t           r_s_color;
  rgb_t           r_s_boxc;
  logic [7:0]     r_s_boxn;

  logic           r_org;
  logic           r_frame;
  logic           w_org;
  logic           w_fs;

  logic [CW-1:0]  r_x1;
  logic [CW-1:0]  r_y1;
  logic [2:0]     r_k1;
  logic [2:0]     w_k;
  logic [BCW-1:0] r_bcnt;
  logic [BCW-1:0] w_bcnt;

  logic [CW:0]    w_bx;
  logic [CW:0]    w_by;
  logic [CW:0]    w_x1;
  logic [CW:0]    w_y1;
  logic [CW:0]    w_n;
  logic           w_inbox;
  logic           w_act;
  logic           w_chk;
  rgb_t           w_rgb;
  rgb_t           r_rgb;
  logic           w_unused;

  assign w_unused = ^regs.i_wdata[31:24];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode  <= '0;
      r_shift <= '0;
      r_color <= '0;
      r_boxc  <= '0;
      r_boxn  <= '0;
      r_boxv  <= '0;
    end else if (regs.i_wr) begin
      case (regs.i_wreg)
        REG_CTRL: begin
          r_mode  <= regs.i_wdata[2:0];
          r_shift <= regs.i_wdata[11:8];
        end
        REG_COLOR: r_color <= regs.i_wdata[23:0];
        REG_BOXC:  r_boxc  <= regs.i_wdata[23:0];
        default: begin
          r_boxn <= regs.i_wdata[7:0];
          r_boxv <= regs.i_wdata[15:8];
        end
      endcase
    end
  end

  always_comb begin
    regs.o_rdata = '0;
    case (regs.i_rreg)
      REG_CTRL:  regs.o_rdata = {20'd0, r_shift, 5'd0, r_mode};
      REG_COLOR: regs.o_rdata = {8'd0, r_color};
      REG_BOXC:  regs.o_rdata = {8'd0, r_boxc};
      default:   regs.o_rdata = {16'd0, r_boxv, r_boxn};
    endcase
  end

  assign w_org = (xpixel == '0) && (ypixel == '0);
  assign w_fs  = w_org && !r_org;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_org     <= 1'b0;
      r_frame   <= 1'b0;
      r_s_mode  <= MODE_SOLID;
      r_s_shift <= '0;
      r_s_color <= '0;
      r_s_boxc  <= '0;
      r_s_boxn  <= '0;
    end else begin
      r_org   <= w_org;
      r_frame <= w_fs;
      if (w_fs) begin
        r_s_mode  <= mode_e'(r_mode);
        r_s_shift <= r_shift;
        r_s_color <= r_color;
        r_s_boxc  <= r_boxc;
        r_s_boxn  <= r_boxn;
      end
    end
  end

  // Motion uses the values being loaded, so geometry matches the new frame.
  vpg_bouncer #(.LIMIT(HWIDTH), .CW(CW)) u_bounce_x (
    .clk    (clk),
    .reset  (reset),
    .i_step (w_fs),
    .i_n    (r_boxn),
    .i_v    (r_boxv),
    .o_pos  (w_bx)
  );

  vpg_bouncer #(.LIMIT(VHEIGHT), .CW(CW)) u_bounce_y (
    .clk    (clk),
    .reset  (reset),
    .i_step (w_fs),
    .i_n    (r_boxn),
    .i_v    (r_boxv),
    .o_pos  (w_by)
  );

  always_comb begin
    w_k    = r_k1;
    w_bcnt = r_bcnt + 1'b1;
    if (xpixel == '0) begin
      w_k    = '0;
      w_bcnt = '0;
    end else if (r_bcnt == BAR_LAST) begin
      w_k    = r_k1 + 3'd1;
      w_bcnt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x1   <= '0;
      r_y1   <= '0;
      r_k1   <= '0;
      r_bcnt <= '0;
    end else begin
      r_x1   <= xpixel;
      r_y1   <= ypixel;
      r_k1   <= w_k;
      r_bcnt <= w_bcnt;
    end
  end

  assign w_x1    = {1'b0, r_x1};
  assign w_y1    = {1'b0, r_y1};
  assign w_n     = {{(CW-7){1'b0}}, r_s_boxn};
  assign w_inbox = (w_x1 >= w_bx) && (w_x1 < w_bx + w_n) &&
                   (w_y1 >= w_by) && (w_y1 < w_by + w_n);
  assign w_act   = (r_x1 < HMAX) && (r_y1 < VMAX);
  assign w_chk   = r_x1[r_s_shift] ^ r_y1[r_s_shift];

  always_comb begin
    w_rgb = '0;
    if (w_act) begin
      unique case (r_s_mode)
        MODE_CHECK: w_rgb = w_chk ? RGB_WHITE : r_s_color;
        MODE_BARS:  w_rgb = bar_rgb(r_k1);
        MODE_GRAD:  w_rgb = {r_x1[7:0], r_y1[7:0], r_s_color.b};
        MODE_BOX:   w_rgb = w_inbox ? r_s_boxc : r_s_color;
        default:    w_rgb = r_s_color;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_rgb;
    end
  end

  assign red     = r_rgb.r;
  assign grn     = r_rgb.g;
  assign blu     = r_rgb.b;
  assign o_frame = r_frame;
endmodule
